uart_rx: RTL

//  8N1 UART receiver, consumer side of the baud generator's 16x rx clock enable.
//  - Synchronises the asynchronous rx line and oversamples it on rxclk_en.
//  - Validates the start bit and samples each bit at mid-bit.
//  - Presents the received byte with a sticky ready flag and error flags.
//  - Sits between the pad and the host/bus-side consumer, in the clk_50m domain.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_if.sv | 46 ++++
 rtl/uart_rx_sync.sv | 37 +++
 rtl/uart_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Purpose : Shared types and constants for the UART receiver slice.
//           Holds the receive FSM state type, the oversampling ratio and the
//           character width, plus counter widths derived from them.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = $clog2(DATA_BITS);

  // Last oversample tick of a bit period; mid-bit sampling happens here
  // because counting restarts at the previous mid-bit point.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module  : uart_rx_if
// Purpose : Consumer-side bus of the UART receiver: received byte, sticky
//           status flags and the acknowledge that clears them.
// Signals : rdy_clr     consumer acknowledge, clears rdy/overrun/parity_err
//           data        last good byte, LSB received first
//           rdy         sticky, a good byte is held in data
//           frame_err   sticky, last frame had a low stop bit
//           overrun     sticky, a byte completed while rdy was still set
//           parity_err  sticky, parity mismatch on the last good byte
// Modports: slave  - the receiver (drives data and flags)
//           master - the consumer (drives rdy_clr)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;

  logic                           rdy_clr;
  logic [uart_pkg::DATA_BITS-1:0] data;
  logic                           rdy;
  logic                           frame_err;
  logic                           overrun;
  logic                           parity_err;

  modport slave (
    input  rdy_clr,
    output data,
    output rdy,
    output frame_err,
    output overrun,
    output parity_err
  );

  modport master (
    output rdy_clr,
    input  data,
    input  rdy,
    input  frame_err,
    input  overrun,
    input  parity_err
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module  : uart_rx_sync
// Purpose : Multi-flop synchroniser bringing the asynchronous serial line
//           into the clk_50m domain. Flops reset to 1 so that a reset never
//           looks like a start bit.
// Ports   : clk_50m   in  1  system clock
//           rst_n     in  1  asynchronous active-low reset
//           async_in  in  1  asynchronous serial input
//           sync_out  out 1  synchronised level, SYNC_STAGES cycles late
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      stages <= '1;
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], async_in};
    end
  end

  assign sync_out = stages[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module  : uart_rx
// Purpose : 8N1 UART receiver driven by a 16x oversampling clock enable.
//           Synchronises rx, qualifies the start bit at MID_TICK, samples
//           each following bit at mid-bit and presents the byte with sticky
//           ready and error flags.
// Ports   : clk_50m  in  1  system clock
//           rst_n    in  1  asynchronous active-low reset
//           rx       in  1  serial input, idle high, asynchronous
//           clken    in  1  one-cycle strobe at 16x baud
//           bus      slave modport of uart_rx_if (byte, flags, rdy_clr)
// Config  : UART_RX_PARITY_EN - adds an even-parity bit between the data
//           bits and the stop bit and drives parity_err; without it the
//           frame is 10 bits and parity_err is constant 0.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MID_TICK    = 7
) (
  input  logic      clk_50m,
  input  logic      rst_n,
  input  logic      rx,
  input  logic      clken,
  uart_rx_if.slave  bus
);

  localparam logic [CNT_W-1:0] MID_CNT = CNT_W'(MID_TICK);

  logic rxs;

  rx_state_t            state,      state_nxt;
  logic [CNT_W-1:0]     sample_cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx,    idx_nxt;
  logic [DATA_BITS-1:0] shift,      shift_nxt;
  logic [DATA_BITS-1:0] data_q,     data_nxt;
  logic                 rdy_q,      rdy_nxt;
  logic                 ferr_q,     ferr_nxt;
  logic                 ovr_q,      ovr_nxt;

`ifdef UART_RX_PARITY_EN
  // Parity result is held here until the stop bit proves the frame good.
  logic                 pbad_q,     pbad_nxt;
  logic                 perr_q,     perr_nxt;
`endif

  uart_rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .async_in (rx),
    .sync_out (rxs)
  );

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_q     <= '0;
      rdy_q      <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q     <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      sample_cnt <= cnt_nxt;
      bit_idx    <= idx_nxt;
      shift      <= shift_nxt;
      data_q     <= data_nxt;
      rdy_q      <= rdy_nxt;
      ferr_q     <= ferr_nxt;
      ovr_q      <= ovr_nxt;
`ifdef UART_RX_PARITY_EN
      pbad_q     <= pbad_nxt;
      perr_q     <= perr_nxt;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cnt_nxt   = sample_cnt;
    idx_nxt   = bit_idx;
    shift_nxt = shift;
    data_nxt  = data_q;
    rdy_nxt   = rdy_q;
    ferr_nxt  = ferr_q;
    ovr_nxt   = ovr_q;
`ifdef UART_RX_PARITY_EN
    pbad_nxt  = pbad_q;
    perr_nxt  = perr_q;
`endif

    // The acknowledge works on any cycle; a byte completing in the same
    // cycle is handled below and overrides it.
    if (bus.rdy_clr) begin
      rdy_nxt  = 1'b0;
      ovr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_nxt = 1'b0;
`endif
    end

    if (clken) begin
      case (state)
        IDLE: begin
          if (!rxs) begin
            state_nxt = START;
            cnt_nxt   = '0;
          end
        end

        START: begin
          if (sample_cnt == MID_CNT) begin
            // Still low at mid start bit: a real start. Otherwise a glitch.
            if (!rxs) begin
              state_nxt = DATA;
              cnt_nxt   = '0;
              idx_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            cnt_nxt = sample_cnt + 1'b1;
          end
        end

        DATA: begin
          cnt_nxt = sample_cnt + 1'b1;
          if (sample_cnt == CNT_LAST) begin
            shift_nxt[bit_idx] = rxs;
            if (bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end else begin
              idx_nxt = bit_idx + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          cnt_nxt = sample_cnt + 1'b1;
          if (sample_cnt == CNT_LAST) begin
            pbad_nxt  = (rxs != ^shift);
            state_nxt = STOP;
          end
        end
`endif

        STOP: begin
          cnt_nxt = sample_cnt + 1'b1;
          if (sample_cnt == CNT_LAST) begin
            if (rxs) begin
              data_nxt = shift;
              rdy_nxt  = 1'b1;
              ferr_nxt = 1'b0;
              ovr_nxt  = rdy_q & ~bus.rdy_clr;
`ifdef UART_RX_PARITY_EN
              perr_nxt = pbad_q;
`endif
            end else begin
              ferr_nxt = 1'b1;
            end
            state_nxt = IDLE;
          end
        end

        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.rdy       = rdy_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire
